// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the ALU: decodes, reads the 16x16 GPR file, builds the immediate, and owns the PSR (ALU_OPERAND_BYPASS_EN forwards same-edge writebacks into A/B/carry).
// Latency: 1 cycle from accept to registered outputs; full throughput with out_ready held high.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled FULL stage holds every output stable.
module alu_operand_stage #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [3:0]        opcode,
   output logic [3:0]        opext,
   output logic [3:0]        dest_idx,
   output logic              carry,
   input  logic              wb_en,
   input  logic [3:0]        wb_idx,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_flags_en,
   input  logic [4:0]        wb_flags
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [4:0]        psr_q, psr_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]        opcode_q, opcode_d, opext_q, opext_d, dest_q, dest_d;
   logic              carry_q, carry_d;

   logic              accept;
   logic [3:0]        rdest, rsrc;
   logic              reg_form;
   logic [DATA_W-1:0] a_src, b_reg, b_src;
   logic              c_src;
   logic              unused_psr;

   assign out_valid = (state_q == FULL);
   assign in_ready  = ~out_valid | out_ready;
   assign accept    = in_valid & in_ready;

   assign rdest    = instr[11:8];
   assign rsrc     = instr[3:0];
   assign reg_form = (instr[15:12] == 4'b0000);

   // Only C feeds this stage; the remaining flags are kept for the rest of the core.
   assign unused_psr = ^psr_q[3:0];

`ifdef ALU_OPERAND_BYPASS_EN
   assign a_src = (wb_en && wb_idx == rdest) ? wb_data : regs_q[rdest];
   assign b_reg = (wb_en && wb_idx == rsrc)  ? wb_data : regs_q[rsrc];
   assign c_src = wb_flags_en ? wb_flags[4] : psr_q[4];
`else
   assign a_src = regs_q[rdest];
   assign b_reg = regs_q[rsrc];
   assign c_src = psr_q[4];
`endif

   assign b_src = reg_form ? b_reg : {{(DATA_W-8){instr[7]}}, instr[7:0]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (accept) state_d = FULL;
         FULL:    if (out_ready && !in_valid) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      opcode_d = opcode_q;
      opext_d  = opext_q;
      dest_d   = dest_q;
      carry_d  = carry_q;
      if (accept) begin
         a_d      = a_src;
         b_d      = b_src;
         opcode_d = instr[15:12];
         opext_d  = instr[7:4];
         dest_d   = rdest;
         carry_d  = c_src;
      end
   end

   always_comb begin
      regs_d = regs_q;
      psr_d  = psr_q;
      if (wb_en)       regs_d[wb_idx] = wb_data;
      if (wb_flags_en) psr_d          = wb_flags;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= EMPTY;
         a_q      <= '0;
         b_q      <= '0;
         opcode_q <= '0;
         opext_q  <= '0;
         dest_q   <= '0;
         carry_q  <= 1'b0;
         psr_q    <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opcode_q <= opcode_d;
         opext_q  <= opext_d;
         dest_q   <= dest_d;
         carry_q  <= carry_d;
         psr_q    <= psr_d;
         regs_q   <= regs_d;
      end
   end

   assign A        = a_q;
   assign B        = b_q;
   assign opcode   = opcode_q;
   assign opext    = opext_q;
   assign dest_idx = dest_q;
   assign carry    = carry_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: reference register/PSR model feeds a scoreboard queue.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] instr, A, B, wb_data;
   logic [3:0]  opcode, opext, dest_idx, wb_idx;
   logic        carry, wb_en, wb_flags_en;
   logic [4:0]  wb_flags;

   always #5 clk = ~clk;

   alu_operand_stage #(.DATA_W(16), .NREGS(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .A(A), .B(B), .opcode(opcode), .opext(opext), .dest_idx(dest_idx), .carry(carry),
      .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
      .wb_flags_en(wb_flags_en), .wb_flags(wb_flags)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [3:0]  ox;
      logic [3:0]  dst;
      logic        c;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] m_regs [16];
   logic [4:0]  m_psr;
   logic        m_full;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      m_psr  = 5'b0;
      m_full = 1'b0;
   endtask

   function automatic exp_t predict(input logic [15:0] ins);
      exp_t e;
      logic [3:0] rd, rs;
      rd    = ins[11:8];
      rs    = ins[3:0];
      e.a   = m_regs[rd];
      e.b   = (ins[15:12] == 4'h0) ? m_regs[rs] : {{8{ins[7]}}, ins[7:0]};
      e.op  = ins[15:12];
      e.ox  = ins[7:4];
      e.dst = rd;
      e.c   = m_psr[4];
`ifdef ALU_OPERAND_BYPASS_EN
      if (wb_en && wb_idx == rd) e.a = wb_data;
      if (ins[15:12] == 4'h0 && wb_en && wb_idx == rs) e.b = wb_data;
      if (wb_flags_en) e.c = wb_flags[4];
`endif
      return e;
   endfunction

   // One clock: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic step();
      logic acc;
      @(negedge clk);
      check("in_ready", 16'(in_ready), 16'(!m_full || out_ready));
      check("out_valid", 16'(out_valid), 16'(m_full));
      if (m_full && sb.size() > 0) begin
         check("A", A, sb[0].a);
         check("B", B, sb[0].b);
         check("opcode", 16'(opcode), 16'(sb[0].op));
         check("opext", 16'(opext), 16'(sb[0].ox));
         check("dest_idx", 16'(dest_idx), 16'(sb[0].dst));
         check("carry", 16'(carry), 16'(sb[0].c));
         if (out_ready) void'(sb.pop_front());
      end
      acc = in_valid && (!m_full || out_ready);
      if (acc) sb.push_back(predict(instr));
      m_full = acc || (m_full && !out_ready);
      if (wb_en) m_regs[wb_idx] = wb_data;
      if (wb_flags_en) m_psr = wb_flags;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; instr = 16'h0; out_ready = 1'b1;
      wb_en = 1'b0; wb_idx = 4'h0; wb_data = 16'h0; wb_flags_en = 1'b0; wb_flags = 5'b0;
      model_reset();
      #1;
      check("rst_in_ready", 16'(in_ready), 16'd1);
      check("rst_out_valid", 16'(out_valid), 16'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Load state, then reset with a FULL stage and nonzero PSR
      wb_flags_en = 1'b1; wb_flags = 5'h1F; wb_en = 1'b1; wb_idx = 4'd3; wb_data = 16'h1111;
      step();
      wb_flags_en = 1'b0; wb_en = 1'b0;
      in_valid = 1'b1; instr = 16'h0354; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("pre_rst_full", 16'(out_valid), 16'd1);
      check("pre_rst_carry", 16'(carry), 16'd1);
      check("pre_rst_A", A, 16'h1111);
      reset_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 16'(out_valid), 16'd0);
      check("mid_rst_carry", 16'(carry), 16'd0);
      check("mid_rst_A", A, 16'h0);
      check("mid_rst_in_ready", 16'(in_ready), 16'd1);
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1; instr = 16'h0354;
      step();
      in_valid = 1'b0;
      check("post_rst_A", A, 16'h0);
      check("post_rst_B", B, 16'h0);
      check("post_rst_carry", 16'(carry), 16'd0);

      // Register-form ADD
      wb_en = 1'b1; wb_idx = 4'd3; wb_data = 16'h1234; step();
      wb_idx = 4'd4; wb_data = 16'h0FFF; step();
      wb_en = 1'b0; in_valid = 1'b1; instr = 16'h0354; step();
      in_valid = 1'b0;
      check("add_valid", 16'(out_valid), 16'd1);
      check("add_A", A, 16'h1234);
      check("add_B", B, 16'h0FFF);
      check("add_opcode", 16'(opcode), 16'd0);
      check("add_opext", 16'(opext), 16'd5);
      check("add_dest", 16'(dest_idx), 16'd3);

      // ADDI sign extension
      wb_en = 1'b1; wb_idx = 4'd3; wb_data = 16'h0010; step();
      wb_en = 1'b0; in_valid = 1'b1; instr = 16'h53F0; step();
      check("addi_neg_A", A, 16'h0010);
      check("addi_neg_B", B, 16'hFFF0);
      check("addi_opcode", 16'(opcode), 16'd5);
      instr = 16'h537F; step();
      in_valid = 1'b0;
      check("addi_pos_B", B, 16'h007F);
      step();

      // Backpressure: second instruction waits, then loads on the consuming edge
      out_ready = 1'b0; in_valid = 1'b1; instr = 16'h0354; step();
      check("stall_in_ready", 16'(in_ready), 16'd0);
      instr = 16'h5322; step(); step();
      check("stall_A", A, 16'h0010);
      check("stall_B", B, 16'h0FFF);
      check("stall_opcode", 16'(opcode), 16'd0);
      out_ready = 1'b1; step();
      in_valid = 1'b0;
      check("nobubble_valid", 16'(out_valid), 16'd1);
      check("nobubble_opcode", 16'(opcode), 16'd5);
      check("nobubble_B", B, 16'h0022);
      step();

      // Same-edge writeback to Rsrc
      in_valid = 1'b1; instr = 16'h0354; wb_en = 1'b1; wb_idx = 4'd4; wb_data = 16'hBEEF; step();
      in_valid = 1'b0; wb_en = 1'b0;
`ifdef ALU_OPERAND_BYPASS_EN
      check("bypass_B", B, 16'hBEEF);
`else
      check("nobypass_B", B, 16'h0FFF);
`endif
      step();

      // Carry snapshot
      wb_flags_en = 1'b1; wb_flags = 5'b10000; step();
      wb_flags_en = 1'b0; in_valid = 1'b1; instr = 16'h0354; step();
      check("carry_set", 16'(carry), 16'd1);
      wb_flags_en = 1'b1; wb_flags = 5'b00000; step();
      wb_flags_en = 1'b0; in_valid = 1'b0;
`ifdef ALU_OPERAND_BYPASS_EN
      check("carry_bypass", 16'(carry), 16'd0);
`else
      check("carry_nobypass", 16'(carry), 16'd1);
`endif
      step();

      // Random traffic with frequent index collisions
      for (int n = 0; n < 300; n++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         instr       = 16'($urandom);
         if ($urandom_range(0, 1) == 0) instr[15:12] = 4'h0;
         instr[11:8] = 4'($urandom_range(0, 3));
         instr[3:0]  = 4'($urandom_range(0, 3));
         out_ready   = ($urandom_range(0, 3) != 0);
         wb_en       = ($urandom_range(0, 1) != 0);
         wb_idx      = 4'($urandom_range(0, 3));
         wb_data     = 16'($urandom);
         wb_flags_en = ($urandom_range(0, 2) == 0);
         wb_flags    = 5'($urandom);
         step();
      end

      in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_flags_en = 1'b0;
      repeat (3) step();
      check("sb_drain", 16'(sb.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch pipeline stage that sits directly upstream of the ALU. It accepts one 16-bit instruction per handshake, decodes the opcode/opext fields and register indices, reads the 16×16 general register file, and builds the immediate. It then presents registered A, B, opcode, opext and carry to the ALU. It also owns the register file write port and the processor status register (PSR) that holds the ALU's CLFZN flags; the PSR is the source of the ALU carry-in.

## Interface
Parameters:
- DATA_W, 16, datapath and register width
- NREGS, 16, register file depth (index width = 4)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- instr  in  16  [15:12] opcode, [11:8] Rdest, [7:4] opext or imm[7:4], [3:0] Rsrc or imm[3:0]
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream consumes operands
- A  out  16  R[Rdest]
- B  out  16  R[Rsrc] or immediate
- opcode  out  4  instr[15:12]
- opext  out  4  instr[7:4]
- dest_idx  out  4  Rdest, carried forward for writeback
- carry  out  1  PSR carry (C) captured with the operands
- wb_en  in  1  register write enable
- wb_idx  in  4  register write index
- wb_data  in  16  register write data (ALU S)
- wb_flags_en  in  1  PSR write enable
- wb_flags  in  5  CLFZN from the ALU; bit 4 = C, bit 1 = Z, bit 2 = F

## Operation
- The output is a single pipeline register. States: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = ~out_valid | out_ready, driven combinationally. Accept condition: in_valid & in_ready.
- EMPTY→FULL on accept. FULL→EMPTY on out_ready & ~in_valid. FULL→FULL on simultaneous consume and accept, with new operands loaded. FULL with ~out_ready holds all outputs stable.
- Register form: opcode == 4'b0000. B = R[Rsrc].
- Immediate form: any other opcode. B = {{8{instr[7]}}, instr[7:0]}, sign-extended. ADDI = 0101.
- opext is always instr[7:4], including immediate forms; the ALU ignores it there.
- A = R[Rdest] in both forms.
- Register writes: on each edge with wb_en=1, R[wb_idx] ← wb_data. Writes are independent of the handshake.
- PSR writes: on each edge with wb_flags_en=1, PSR ← wb_flags.
- carry is a snapshot of PSR[4], taken at accept.
- Width rules: no arithmetic is done here; all operands are exactly 16 bits.

## Timing
- Latency is one cycle: instruction accepted at edge N appears on the outputs after edge N.
- Throughput is one instruction per cycle when out_ready is held high.
- Reset values (asynchronous, on reset_n low): out_valid=0, A=0, B=0, opcode=0, opext=0, dest_idx=0, carry=0, PSR=0, all R[i]=0. in_ready=1 during and after reset.
- Reset mid-operation: a FULL stage is dropped without being consumed, and register/PSR contents are lost. The first accept is allowed on the first edge after reset_n deasserts.
- Simultaneous writeback and accept to the same index: behaviour is set by Configuration. PSR writeback plus accept in the same cycle is handled the same way for carry.
- Writes to a register already latched in a FULL stage do not alter A/B. The producer guarantees hazard spacing.

## Configuration
- ALU_OPERAND_BYPASS_EN defined:
  - If wb_en & (wb_idx == Rdest) in the accept cycle, A captures wb_data.
  - If wb_en & (wb_idx == Rsrc) in the accept cycle, a register-form B captures wb_data.
  - If wb_flags_en, carry captures wb_flags[4].
- Undefined: the captured A, B and carry are the pre-write values, i.e. write-after-read ordering at the same edge.

## Test plan
- Reset with out_valid=1 and a nonzero PSR → immediately out_valid=0 and carry=0; after release in_ready=1 and all registers read 0.
- Write R3=0x1234 and R4=0x0FFF, then issue ADD instr 0x0354 → next cycle out_valid=1, A=0x1234, B=0x0FFF, opcode=0, opext=5, dest_idx=3.
- ADDI instr 0x53F0 with R3=0x0010 → A=0x0010, B=0xFFF0; instr 0x537F → B=0x007F.
- Hold out_ready=0 with two instructions offered → first held stable, in_ready=0, second not accepted; raise out_ready → second loaded on the same edge, no bubble.
- Same-cycle wb_en (R4←0xBEEF) plus accept of 0x0354 → B=0xBEEF with ALU_OPERAND_BYPASS_EN defined, old R4 value without it.
- wb_flags=5'b10000 written, then an ADD accepted → carry=1; wb_flags=0 on the accept edge → carry is 0 with the macro defined, 1 without.
